// File: rtl/cosine_ctrl.sv
// Control FSM for the iterative Q8.8 Taylor-series cosine datapath.
// One Moore control word per clock; terminates on the threshold compare or the term limit.
module cosine_ctrl #(
    parameter int MAX_TERMS = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_neg_flag,
    output logic o_ready,
    output logic o_busy,
    output logic o_init_0,
    output logic o_ld_x,
    output logic o_ld_y,
    output logic o_i_ans,
    output logic o_i_temp,
    output logic o_idff,
    output logic o_x_en,
    output logic o_rom_en,
    output logic o_ld_temp,
    output logic o_cnt_en,
    output logic o_ff_en,
    output logic o_y_en,
    output logic o_ans_en,
    output logic o_ld_ans,
    output logic o_ans_ready
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LOAD  = 4'd1,
        S_MULX1 = 4'd2,
        S_MULR1 = 4'd3,
        S_MULX2 = 4'd4,
        S_MULR2 = 4'd5,
        S_CMP   = 4'd6,
        S_ACC   = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    // tc holds the number of terms already accumulated, so the last ACC sees MAX_TERMS-1.
    localparam logic [2:0] TC_LAST = 3'(MAX_TERMS - 1);

    state_t      r_state;
    logic [16:0] r_ctrl;
    logic [2:0]  r_tc;

    // Control word order: ready, busy, init_0, ld_x, ld_y, i_ans, i_temp, idff,
    // x_en, rom_en, ld_temp, cnt_en, ff_en, y_en, ans_en, ld_ans, ans_ready.
    function automatic logic [16:0] ctrl_word(input state_t st);
        logic [16:0] w;
        case (st)
            S_IDLE:  w = 17'b1_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0;
            S_LOAD:  w = 17'b0_1_1_1_1_1_1_1_0_0_0_0_0_0_0_0_0;
            S_MULX1: w = 17'b0_1_0_0_0_0_0_0_1_0_1_0_0_0_0_0_0;
            S_MULR1: w = 17'b0_1_0_0_0_0_0_0_0_1_1_1_0_0_0_0_0;
            S_MULX2: w = 17'b0_1_0_0_0_0_0_0_1_0_1_0_0_0_0_0_0;
            S_MULR2: w = 17'b0_1_0_0_0_0_0_0_0_1_1_1_1_0_0_0_0;
            S_CMP:   w = 17'b0_1_0_0_0_0_0_0_0_0_0_0_0_1_0_0_0;
            S_ACC:   w = 17'b0_1_0_0_0_0_0_0_0_0_0_0_0_0_1_1_0;
            S_DONE:  w = 17'b0_1_0_0_0_0_0_0_0_0_0_0_0_0_0_0_1;
            default: w = 17'b1_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0;
        endcase
        return w;
    endfunction

    // State, term counter and the registered control word for the entered state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ctrl  <= ctrl_word(S_IDLE);
            r_tc    <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_LOAD;
                        r_ctrl  <= ctrl_word(S_LOAD);
                    end else begin
                        r_state <= S_IDLE;
                        r_ctrl  <= ctrl_word(S_IDLE);
                    end
                end
                S_LOAD: begin
                    r_tc    <= 3'd0;
                    r_state <= S_MULX1;
                    r_ctrl  <= ctrl_word(S_MULX1);
                end
                S_MULX1: begin
                    r_state <= S_MULR1;
                    r_ctrl  <= ctrl_word(S_MULR1);
                end
                S_MULR1: begin
                    r_state <= S_MULX2;
                    r_ctrl  <= ctrl_word(S_MULX2);
                end
                S_MULX2: begin
                    r_state <= S_MULR2;
                    r_ctrl  <= ctrl_word(S_MULR2);
                end
                S_MULR2: begin
                    r_state <= S_CMP;
                    r_ctrl  <= ctrl_word(S_CMP);
                end
                S_CMP: begin
                    // A term below the threshold is dropped rather than accumulated.
                    if (i_neg_flag) begin
                        r_state <= S_DONE;
                        r_ctrl  <= ctrl_word(S_DONE);
                    end else begin
                        r_state <= S_ACC;
                        r_ctrl  <= ctrl_word(S_ACC);
                    end
                end
                S_ACC: begin
                    r_tc <= r_tc + 3'd1;
                    if (r_tc == TC_LAST) begin
                        r_state <= S_DONE;
                        r_ctrl  <= ctrl_word(S_DONE);
                    end else begin
                        r_state <= S_MULX1;
                        r_ctrl  <= ctrl_word(S_MULX1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ctrl  <= ctrl_word(S_IDLE);
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ctrl  <= ctrl_word(S_IDLE);
                    r_tc    <= 3'd0;
                end
            endcase
        end
    end

    assign o_ready     = r_ctrl[16];
    assign o_busy      = r_ctrl[15];
    assign o_init_0    = r_ctrl[14];
    assign o_ld_x      = r_ctrl[13];
    assign o_ld_y      = r_ctrl[12];
    assign o_i_ans     = r_ctrl[11];
    assign o_i_temp    = r_ctrl[10];
    assign o_idff      = r_ctrl[9];
    assign o_x_en      = r_ctrl[8];
    assign o_rom_en    = r_ctrl[7];
    assign o_ld_temp   = r_ctrl[6];
    assign o_cnt_en    = r_ctrl[5];
    assign o_ff_en     = r_ctrl[4];
    assign o_y_en      = r_ctrl[3];
    assign o_ans_en    = r_ctrl[2];
    assign o_ld_ans    = r_ctrl[1];
    assign o_ans_ready = r_ctrl[0];

endmodule

// File: tb/tb_cosine_ctrl.sv
// Directed bench for cosine_ctrl: checks every control word of each run against
// a hand-written per-state table, plus pulse counts and the DONE edge.
module tb_cosine_ctrl;

    localparam logic [16:0] W_IDLE = 17'b1_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [16:0] W_LOAD = 17'b0_1_1_1_1_1_1_1_0_0_0_0_0_0_0_0_0;
    localparam logic [16:0] W_MULX = 17'b0_1_0_0_0_0_0_0_1_0_1_0_0_0_0_0_0;
    localparam logic [16:0] W_MR1  = 17'b0_1_0_0_0_0_0_0_0_1_1_1_0_0_0_0_0;
    localparam logic [16:0] W_MR2  = 17'b0_1_0_0_0_0_0_0_0_1_1_1_1_0_0_0_0;
    localparam logic [16:0] W_CMP  = 17'b0_1_0_0_0_0_0_0_0_0_0_0_0_1_0_0_0;
    localparam logic [16:0] W_ACC  = 17'b0_1_0_0_0_0_0_0_0_0_0_0_0_0_1_1_0;
    localparam logic [16:0] W_DONE = 17'b0_1_0_0_0_0_0_0_0_0_0_0_0_0_0_0_1;

    logic clk;
    logic rst;
    logic start;
    logic neg_flag;
    logic ready, busy, init_0, ld_x, ld_y, i_ans, i_temp, idff;
    logic x_en, rom_en, ld_temp, cnt_en, ff_en, y_en, ans_en, ld_ans, ans_ready;

    int   n_tests;
    int   n_fail;
    int   cmp_seen;
    int   neg_at;
    logic noise;

    logic [16:0] obs;

    cosine_ctrl #(.MAX_TERMS(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start),
        .i_neg_flag (neg_flag),
        .o_ready    (ready),
        .o_busy     (busy),
        .o_init_0   (init_0),
        .o_ld_x     (ld_x),
        .o_ld_y     (ld_y),
        .o_i_ans    (i_ans),
        .o_i_temp   (i_temp),
        .o_idff     (idff),
        .o_x_en     (x_en),
        .o_rom_en   (rom_en),
        .o_ld_temp  (ld_temp),
        .o_cnt_en   (cnt_en),
        .o_ff_en    (ff_en),
        .o_y_en     (y_en),
        .o_ans_en   (ans_en),
        .o_ld_ans   (ld_ans),
        .o_ans_ready(ans_ready)
    );

    assign obs = {ready, busy, init_0, ld_x, ld_y, i_ans, i_temp, idff,
                  x_en, rom_en, ld_temp, cnt_en, ff_en, y_en, ans_en, ld_ans, ans_ready};

    // Datapath stub: neg_flag fires in the chosen CMP only; outside CMP it carries noise.
    assign neg_flag = y_en ? (cmp_seen == neg_at) : noise;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Starts a run from IDLE at a negedge and checks the word after every edge.
    task automatic run(input string name, input int neg_term, input logic hold,
                       input int p0, input int p1, input int p2,
                       input int exp_done, input int exp_acc, input int exp_cnt, input int exp_ff);
        logic [16:0] q[$];
        bit done;
        int n_acc, n_cnt, n_ff, n_rdy, done_edge;
        q = {};
        done = 1'b0;
        q.push_back(W_LOAD);
        for (int t = 1; t <= 6 && !done; t++) begin
            q.push_back(W_MULX);
            q.push_back(W_MR1);
            q.push_back(W_MULX);
            q.push_back(W_MR2);
            q.push_back(W_CMP);
            if (t == neg_term) done = 1'b1;
            else q.push_back(W_ACC);
        end
        q.push_back(W_DONE);

        neg_at = neg_term;
        cmp_seen = 0;
        n_acc = 0; n_cnt = 0; n_ff = 0; n_rdy = 0; done_edge = -1;
        start = 1'b1;
        for (int n = 0; n < q.size(); n++) begin
            @(posedge clk);
            @(negedge clk);
            start = hold || (n + 1 == p0) || (n + 1 == p1) || (n + 1 == p2);
            noise = n[0];
            if (y_en) cmp_seen++;
            check_eq($sformatf("%s_word_e%0d", name, n), 32'(obs), 32'(q[n]));
            if (ans_en)    n_acc++;
            if (cnt_en)    n_cnt++;
            if (ff_en)     n_ff++;
            if (ans_ready) begin
                n_rdy++;
                done_edge = n;
            end
        end
        check_eq({name, "_done_edge"}, 32'(done_edge), 32'(exp_done));
        check_eq({name, "_ans_ready_n"}, 32'(n_rdy), 32'd1);
        check_eq({name, "_acc_n"}, 32'(n_acc), 32'(exp_acc));
        check_eq({name, "_cnt_en_n"}, 32'(n_cnt), 32'(exp_cnt));
        check_eq({name, "_ff_en_n"}, 32'(n_ff), 32'(exp_ff));
        @(posedge clk);
        @(negedge clk);
        check_eq({name, "_idle_after"}, 32'(obs), 32'(W_IDLE));
        if (hold) begin
            @(posedge clk);
            @(negedge clk);
            check_eq({name, "_reload"}, 32'(obs), 32'(W_LOAD));
            start = 1'b0;
            do_reset();
        end else begin
            start = 1'b0;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        cmp_seen = 0;
        neg_at = 0;
        noise = 1'b0;
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_eq("reset_word", 32'(obs), 32'(W_IDLE));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_hold", 32'(obs), 32'(W_IDLE));

        run("imm", 1, 1'b0, -1, -1, -1, 6, 0, 2, 1);
        run("full", 0, 1'b0, -1, -1, -1, 37, 6, 12, 6);
        run("thr3", 3, 1'b0, -1, -1, -1, 18, 2, 6, 3);

        // Mid-run reset while in MULR1.
        neg_at = 0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_mulr1", 32'(obs), 32'(W_MR1));
        rst = 1'b1;
        #1;
        check_eq("mid_rst_async", 32'(obs), 32'(W_IDLE));
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_hold", 32'(obs), 32'(W_IDLE));
        rst = 1'b0;
        @(negedge clk);
        run("replay", 0, 1'b0, -1, -1, -1, 37, 6, 12, 6);

        run("ign_start", 0, 1'b0, 3, 10, 20, 37, 6, 12, 6);
        run("hold", 0, 1'b1, -1, -1, -1, 37, 6, 12, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cosine_ctrl.md
# cosine_ctrl

Controller FSM for the iterative Taylor-series cosine datapath: `cos(x) = 1 - x²/2! + x⁴/4! - …` in Q8.8. It accepts a start request from the host and drives every control line of the datapath, one control word per clock. It reads back the datapath's `neg_flag` to stop at the threshold or at the term limit. It pulses `ans_ready` when the datapath's answer register holds the result.

## Interface
- `MAX_TERMS`, default 6: maximum non-constant terms accumulated. The 12-entry 1/n constant ROM limits the legal range to 1..6.

Ports:
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: host request. Sampled only in IDLE.
- `neg_flag` in 1: datapath adder sum bit 15. Combinational; sampled only in CMP.
- `ready` out 1: high only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `init_0` out 1: clear the ROM address counter.
- `ld_x`, `ld_y` out 1: load x (Q8.8) and threshold y (Q0.8, zero-extended).
- `i_ans`, `i_temp` out 1: initialise the answer and term registers to 1.0 (16'h0100).
- `idff` out 1: clear the sign flip-flop.
- `x_en` out 1: select x as the multiplier operand.
- `rom_en` out 1: select ROM[cnt] as the multiplier operand.
- `ld_temp` out 1: term register ← product.
- `cnt_en` out 1: ROM address counter +1.
- `ff_en` out 1: toggle the sign flip-flop.
- `y_en` out 1: adder computes temp − y, used for the threshold compare.
- `ans_en` out 1: adder computes ans ± temp; the sign comes from the sign flip-flop.
- `ld_ans` out 1: answer register ← adder sum.
- `ans_ready` out 1: one-cycle result-valid pulse.

## Operation
- Moore decoding: every control output is a function of the current state only. Any output not listed for a state is 0.
- States and asserted outputs:
  - IDLE: `ready`. Next state LOAD if `start`, else IDLE.
  - LOAD: `ld_x`, `ld_y`, `i_ans`, `i_temp`, `init_0`, `idff`. Clears the internal term counter `tc` to 0. Next state MULX1.
  - MULX1: `x_en`, `ld_temp`. Next state MULR1.
  - MULR1: `rom_en`, `ld_temp`, `cnt_en`. Next state MULX2.
  - MULX2: `x_en`, `ld_temp`. Next state MULR2.
  - MULR2: `rom_en`, `ld_temp`, `cnt_en`, `ff_en`. Next state CMP.
  - CMP: `y_en`. Next state DONE if `neg_flag` (term < y, so the term is discarded), else ACC.
  - ACC: `ans_en`, `ld_ans`. `tc` ← `tc`+1. Next state DONE if `tc`+1 == `MAX_TERMS`, else MULX1.
  - DONE: `ans_ready`. Next state IDLE.
- The term recurrence is `term_k = term_{k-1}·x·x·(1/(2k−1))·(1/(2k))`. The ROM address advances twice per term, so MAX_TERMS=6 consumes exactly addresses 0..11.
- Sign alternation: the sign flip-flop is 0 after LOAD. `ff_en` in MULR2 sets it to 1 before the first ACC, so the first term is subtracted. It alternates on every later term.
- `tc` is 3 bits wide, internal, and reset to 0.
- `start` while busy is ignored, not queued. `start` held high through DONE begins a new run on the IDLE cycle after DONE.
- `neg_flag` in any state other than CMP is ignored.

## Timing
- Reset values:
  - State = IDLE.
  - `ready` = 1.
  - `busy` = 0.
  - All datapath controls and `ans_ready` = 0.
  - `tc` = 0.
- `rst` asserted mid-run forces IDLE immediately, with outputs at their reset values. The partial result is discarded.
- Let edge 0 be the edge that samples `start` in IDLE. LOAD is active in the cycle after edge 0.
- Each term takes 6 cycles (MULX1..ACC).
- Run ending on the term limit: DONE is entered at edge `1 + 6·MAX_TERMS`, which is 37 for the default.
- Run ending on the threshold after k accumulated terms: DONE is entered at edge `1 + 6k + 5`.
- `ans_ready` is high for exactly 1 cycle, and the datapath `ans` is stable and valid during that cycle.
- `ready` returns to 1 the cycle after DONE. Minimum start-to-start spacing is 39 cycles for a full run.

## Test plan
- Reset values and mid-run reset: assert `rst` during MULR1 → all outputs 0 except `ready`=1 that same cycle. A subsequent `start` replays the full sequence from LOAD.
- Immediate threshold: `neg_flag` stub = 1 in the first CMP → control word sequence LOAD, MULX1, MULR1, MULX2, MULR2, CMP, DONE. `ans_ready` high at edge 6 only. `ans_en` never asserted.
- Full run: `neg_flag` = 0 always → exactly 6 ACC states, 12 `cnt_en` pulses and 6 `ff_en` pulses. DONE entered at edge 37.
- Threshold at the third term: `neg_flag` = 1 only in the third CMP → 2 ACC pulses, DONE at edge 18.
- Ignored start: pulse `start` at edges 3, 10 and 20 during a full run → no restart and no perturbation of the sequence. `start` held high → the second LOAD follows DONE by exactly 2 cycles (DONE, IDLE, LOAD).
- Integrated with the datapath, x=16'h0000, y=8'h01 → ans=16'h0100 at `ans_ready`. With x=16'h0100, y=8'h00 → ans=16'h008A ±2 LSB (cos 1 ≈ 0.5403).
